// File: rtl/pattern_seq_tx.sv
// Serial pattern transmitter: emits PATTERN MSB-first num_i times with gap_i idle cycles between.
// Optional feature macro: PATTERN_TX_PARITY_EN appends an even-parity bit to every pattern.
module pattern_seq_tx #(
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_i,
    input  logic [3:0]       gap_i,
    input  logic             abort_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sent_cnt_o
);

    localparam int               IDX_W   = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       gap_q;
    logic [3:0]       gap_cnt_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] sent_q;
    logic             d_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [IDX_W-1:0] idx_dec;
    logic [CNT_W-1:0] sent_inc;
    logic             last_beat;

    assign idx_dec  = idx_q - 1'b1;
    assign sent_inc = (sent_q == '1) ? sent_q : sent_q + CNT_W'(1);

`ifdef PATTERN_TX_PARITY_EN
    localparam logic PAR_BIT = ^PATTERN;
    logic par_q;
    // With parity the pattern ends on the parity beat, not on bit 0.
    assign last_beat = par_q;
`else
    assign last_beat = (idx_q == '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            num_q     <= '0;
            sent_q    <= '0;
            d_q       <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort_i && state_q != IDLE) begin
                state_q <= IDLE;
                d_q     <= 1'b0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
                par_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i && num_i != '0) begin
                            num_q   <= num_i;
                            gap_q   <= gap_i;
                            sent_q  <= '0;
                            idx_q   <= IDX_TOP;
                            d_q     <= PATTERN[PAT_W-1];
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= SEND;
                        end
                    end
                    SEND: begin
                        if (last_beat) begin
                            sent_q <= sent_inc;
`ifdef PATTERN_TX_PARITY_EN
                            par_q  <= 1'b0;
`endif
                            if (sent_inc == num_q) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                                d_q     <= 1'b0;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end else if (gap_q != '0) begin
                                state_q   <= GAP;
                                gap_cnt_q <= gap_q - 4'd1;
                                d_q       <= 1'b0;
                                valid_q   <= 1'b0;
                            end else begin
                                idx_q <= IDX_TOP;
                                d_q   <= PATTERN[PAT_W-1];
                            end
`ifdef PATTERN_TX_PARITY_EN
                        end else if (idx_q == '0) begin
                            par_q <= 1'b1;
                            d_q   <= PAR_BIT;
`endif
                        end else begin
                            idx_q <= idx_dec;
                            d_q   <= PATTERN[idx_dec];
                        end
                    end
                    GAP: begin
                        if (gap_cnt_q == '0) begin
                            state_q <= SEND;
                            idx_q   <= IDX_TOP;
                            d_q     <= PATTERN[PAT_W-1];
                            valid_q <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign d_o        = d_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign sent_cnt_o = sent_q;

endmodule

// File: tb/tb_pattern_seq_tx.sv
// Scoreboard bench for pattern_seq_tx: expected bit/done events are timestamped per cycle from
// the repetition arithmetic and matched by an independent monitor.
module tb_pattern_seq_tx;

    localparam int         PAT_W   = 4;
    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         CNT_W   = 8;
`ifdef PATTERN_TX_PARITY_EN
    localparam int B = PAT_W + 1;
`else
    localparam int B = PAT_W;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] num_i = '0;
    logic [3:0]       gap_i = '0;
    logic             abort_i = 1'b0;
    logic             d_o, valid_o, busy_o, done_o;
    logic [CNT_W-1:0] sent_cnt_o;

    pattern_seq_tx #(.PAT_W(PAT_W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_i(num_i), .gap_i(gap_i),
        .abort_i(abort_i), .d_o(d_o), .valid_o(valid_o), .busy_o(busy_o),
        .done_o(done_o), .sent_cnt_o(sent_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   kind;   // 0 = data bit, 1 = done pulse
        logic d;
        int   at;
        int   sent;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_bit(input int j);
        logic [PAT_W-1:0] pat;
        pat = PATTERN;
        if (j < PAT_W) return pat[PAT_W-1-j];
        return ^pat;
    endfunction

    always @(negedge clk) begin
        ev_t e;
        if (valid_o || done_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: valid=%0d done=%0d with nothing expected (cycle %0d)",
                         valid_o, done_o, cyc);
            end else begin
                e = q.pop_front();
                check("event_kind", valid_o ? 0 : 1, e.kind);
                check("event_cycle", cyc, e.at);
                if (e.kind == 0) begin
                    check("data_bit", int'(d_o), int'(e.d));
                end else begin
                    check("done_sent", int'(sent_cnt_o), e.sent);
                    check("done_busy", int'(busy_o), 0);
                end
            end
        end else if (q.size() > 0 && q[0].at < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_output: kind %0d due cycle %0d never seen (now %0d)", e.kind, e.at, cyc);
        end
    end

    // cut_kind: 0 none, 1 abort, 2 reset; cut_off = edge offset from the start edge
    task automatic run_tx(input int num, input int gap, input int cut_kind, input int cut_off);
        int   t0, total, fin, exp_sent;
        ev_t  e;
        start_i = 1'b1;
        num_i   = CNT_W'(num);
        gap_i   = 4'(gap);
        @(posedge clk);
        #1;
        t0    = cyc;
        total = num * B + (num - 1) * gap;
        fin   = (cut_kind != 0) ? cut_off : total;
        check("busy_after_start", int'(busy_o), 1);
        exp_sent = 0;
        for (int r = 0; r < num; r++) begin
            for (int j = 0; j < B; j++) begin
                if (r * (B + gap) + j < fin) begin
                    e.kind = 0; e.d = model_bit(j); e.at = t0 + r * (B + gap) + j; e.sent = 0;
                    q.push_back(e);
                end
            end
            if (r * (B + gap) + B < fin) exp_sent++;
        end
        if (cut_kind == 0) begin
            e.kind = 1; e.d = 1'b0; e.at = t0 + total; e.sent = num;
            q.push_back(e);
        end
        do begin
            @(negedge clk);
            start_i = 1'($urandom);
            num_i   = CNT_W'($urandom);
            gap_i   = 4'($urandom);
        end while (cyc < t0 + fin - 1);
        start_i = 1'b0;
        if (cut_kind == 1) abort_i = 1'b1;
        if (cut_kind == 2) rst = 1'b0;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        rst     = 1'b1;
        if (cut_kind != 0) begin
            check("cut_busy", int'(busy_o), 0);
            check("cut_valid", int'(valid_o), 0);
            check("cut_done", int'(done_o), 0);
            check("cut_d", int'(d_o), 0);
            check("cut_sent", int'(sent_cnt_o), (cut_kind == 2) ? 0 : exp_sent);
        end
    endtask

    task automatic zero_start();
        start_i = 1'b1;
        num_i   = '0;
        gap_i   = 4'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("zero_start_busy", int'(busy_o), 0);
        @(posedge clk);
        #1;
        check("zero_start_busy2", int'(busy_o), 0);
        check("zero_start_done", int'(done_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int num, gap, kind, total;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d", int'(d_o), 0);
        check("reset_valid", int'(valid_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_sent", int'(sent_cnt_o), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_tx(3, 2, 0, 0);
        run_tx(2, 0, 0, 0);
        run_tx(5, 1, 1, B + 1 + 3);   // abort on the second pattern's third bit
        zero_start();
        run_tx(3, 2, 2, B + 1);       // reset inside the first gap
        run_tx(1, 0, 0, 0);
`ifdef PATTERN_TX_PARITY_EN
        run_tx(2, 1, 0, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            num   = $urandom_range(6, 1);
            gap   = $urandom_range(15, 0);
            total = num * B + (num - 1) * gap;
            kind  = $urandom_range(9, 0);
            if (kind == 0) run_tx(num, gap, 2, $urandom_range(total, 1));
            else if (kind < 3) run_tx(num, gap, 1, $urandom_range(total, 1));
            else if (kind == 3) zero_start();
            else run_tx(num, gap, 0, 0);
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_seq_tx.md
# pattern_seq_tx

Serial pattern transmitter: on a start request it emits a programmed PAT_W-bit pattern MSB-first as a valid-qualified bit stream, repeated a requested number of times with a programmable idle gap between repetitions. It is the source side of the serial `d`/`valid` pattern interface. Its output pair drives a pattern detector's data and valid inputs directly, giving self-checking stimulus with a known expected detection count.

## Interface
- PAT_W, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, pattern value; bit PAT_W-1 is sent first
- CNT_W, 8, width of repeat count and sent counter
- clk  input  1  clock; all logic on posedge
- rst  input  1  synchronous, active-low reset; sampled on posedge clk
- start_i  input  1  start request, sampled only in IDLE
- num_i  input  CNT_W  number of pattern repetitions; latched at start
- gap_i  input  4  idle cycles between repetitions; latched at start
- abort_i  input  1  synchronous abort; ends the transfer immediately
- d_o  output  1  serial data bit; registered
- valid_o  output  1  d_o qualifier; registered
- busy_o  output  1  transfer in progress
- done_o  output  1  one-cycle pulse when all repetitions complete
- sent_cnt_o  output  CNT_W  patterns fully emitted in the current or last transfer

## Operation
- Moore FSM: IDLE, SEND, GAP. All outputs are registered functions of state and datapath registers.
- Reset (rst=0 at posedge): state IDLE; d_o=0, valid_o=0, busy_o=0, done_o=0, sent_cnt_o=0; bit index, gap counter, and latched num/gap all 0.
- IDLE: start_i=1 with num_i≠0 latches num_i/gap_i, clears sent_cnt_o, loads bit index PAT_W-1, and moves to SEND. start_i with num_i=0 is ignored: no busy_o, no done_o.
- SEND: each cycle drives d_o=PATTERN[idx] with valid_o=1, then decrements idx. On the last bit (idx=0), sent_cnt_o increments. If sent_cnt_o+1 equals the latched num, the FSM goes to IDLE with done_o=1. Otherwise it goes to GAP if gap≠0, or reloads idx and stays in SEND if gap=0.
- GAP: valid_o=0, d_o=0 for exactly the latched gap cycles, then SEND with idx=PAT_W-1.
- start_i outside IDLE is ignored. num_i/gap_i changes during a transfer have no effect.
- abort_i=1 in SEND or GAP: next state IDLE, valid_o=0, d_o=0, busy_o=0, done_o=0, sent_cnt_o holds its value. abort_i in IDLE has no effect. abort_i has priority over all other transitions.
- Reset mid-transfer returns to the reset values above on that edge. The partial pattern is not completed.
- sent_cnt_o saturates at 2^CNT_W-1 and cannot wrap, because num ≤ 2^CNT_W-1.

## Timing
- Start accepted at edge T: first bit appears on d_o/valid_o in the cycle after T. Latency is 1 cycle.
- busy_o=1 from edge T up to the edge that asserts done_o, abort, or reset.
- Transfer length from edge T to the done edge: num·B + (num-1)·gap cycles, where B=PAT_W (or PAT_W+1 with parity).
- done_o is high for exactly one cycle, coincident with busy_o=0 and valid_o=0. A new start_i is accepted in that same cycle.
- sent_cnt_o updates in the cycle after the last bit of each pattern.

## Configuration
- PATTERN_TX_PARITY_EN defined: after the last pattern bit, one extra SEND cycle drives the even-parity bit (XOR of PATTERN) with valid_o=1. sent_cnt_o increments on the parity cycle instead of on bit 0, and B=PAT_W+1.
- Macro undefined: no parity cycle and B=PAT_W.

## Test plan
- Default params, num_i=3, gap_i=2, start at edge T → stream 1011,00(invalid),1011,00(invalid),1011. done_o at edge T+16, sent_cnt_o=3, and a downstream Moore detector counts 3.
- num_i=2, gap_i=0 → valid_o high for 8 consecutive cycles with d_o=10111011. done_o at T+8.
- num_i=5, gap_i=1, abort_i pulsed in the second pattern's third bit → valid_o=0 on the next cycle, busy_o=0, no done_o, sent_cnt_o=1.
- start_i held high during a transfer, and num_i=0 start in IDLE → no restart, no extra patterns, and the num_i=0 start gives no busy_o/done_o.
- rst=0 mid-GAP, then rst=1 and start with num_i=1 → all outputs 0 after reset, then a single clean 1011 and sent_cnt_o=1.
- PATTERN_TX_PARITY_EN defined, num_i=2, gap_i=1 → 10111, gap, 10111 (parity 1). done_o at T+11.
